systolic_seq_ctrl: RTL and testbench

- Sequencer for an N x N output-stationary systolic array of PE cells. Each cell accumulates a*b every clock and forwards a to the right and b downward.
- Per run, the block performs these steps in order:
  - clears the cell accumulators;
  - issues skewed row and column operand indices for the A and B buffers;
  - lets the wavefront drain;
  - steps a row-select across the C_out results for readout;
  - pulses done.
- Sits between the top-level command interface and the operand buffers / array.

---
 rtl/systolic_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - run sequencer for an N x N output-stationary systolic array
module systolic_seq_ctrl #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_clr,
    output logic                 pe_hold,
    output logic [N*IDX_W-1:0]   a_idx,
    output logic [N-1:0]         a_vld,
    output logic [N*IDX_W-1:0]   b_idx,
    output logic [N-1:0]         b_vld,
    output logic                 c_rd_vld,
    output logic [IDX_W-1:0]     c_rd_row
);

    // Feed counter must hold 0..3N-3; lane offsets t-i are formed at this width.
    localparam int T_W = $clog2(3*N-2);
    localparam logic [T_W-1:0]   T_LAST   = T_W'(3*N-3);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(N-1);

    if (IDX_W != $clog2(N)) begin : g_bad_idx_w
        $error("systolic_seq_ctrl: IDX_W must equal clog2(N)");
    end
    if (N < 2 || N > 16) begin : g_bad_n
        $error("systolic_seq_ctrl: N must be in 2..16");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_HOLD  = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [T_W-1:0]    t;
    logic [IDX_W-1:0]  row;
    logic [N-1:0]      lane_vld;
    logic [N*IDX_W-1:0] lane_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Feed cycle counter and readout row counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            t   <= '0;
            row <= '0;
        end else begin
            case (state)
                S_CLEAR: t <= '0;
                S_FEED:  t <= (t == T_LAST) ? '0 : t + T_W'(1);
                S_HOLD:  row <= '0;
                S_READ:  row <= (row == ROW_LAST) ? '0 : row + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state decode; start is honoured only from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (t == T_LAST) state_nxt = S_HOLD;
            S_HOLD:  state_nxt = S_READ;
            S_READ:  if (row == ROW_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_CLEAR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state and counters.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        pe_clr   = 1'b0;
        pe_hold  = 1'b0;
        c_rd_vld = 1'b0;
        c_rd_row = '0;
        lane_vld = '0;
        lane_idx = '0;
        case (state)
            S_CLEAR: begin
                busy   = 1'b1;
                pe_clr = 1'b1;
            end
            S_FEED: begin
                busy = 1'b1;
                // Lane i carries k = t-i while 0 <= k <= N-1; the skew makes
                // A[i][k] and B[k][j] meet at PE(i,j) on feed cycle k+i+j.
                for (int i = 0; i < N; i++) begin
                    if (int'(t) >= i && int'(t) <= i + N - 1) begin
                        lane_vld[i] = 1'b1;
                        lane_idx[i*IDX_W +: IDX_W] = IDX_W'(t - T_W'(i));
                    end
                end
            end
            S_HOLD: begin
                busy    = 1'b1;
                pe_hold = 1'b1;
            end
            S_READ: begin
                busy     = 1'b1;
                pe_hold  = 1'b1;
                c_rd_vld = 1'b1;
                c_rd_row = row;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Square array: row and column skews are identical.
    assign a_vld = lane_vld;
    assign a_idx = lane_idx;
    assign b_vld = lane_vld;
    assign b_idx = lane_idx;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed vector bench for systolic_seq_ctrl
module tb_systolic_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2;

    logic       busy, done, pe_clr, pe_hold, c_rd_vld;
    logic [1:0] c_rd_row;
    logic [7:0] a_idx, b_idx;
    logic [3:0] a_vld, b_vld;

    logic       busy2, done2, pe_clr2, pe_hold2, c_rd_vld2;
    logic [0:0] c_rd_row2;
    logic [1:0] a_idx2, b_idx2;
    logic [1:0] a_vld2, b_vld2;

    systolic_seq_ctrl #(.N(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pe_clr(pe_clr), .pe_hold(pe_hold), .a_idx(a_idx), .a_vld(a_vld),
        .b_idx(b_idx), .b_vld(b_vld), .c_rd_vld(c_rd_vld), .c_rd_row(c_rd_row)
    );

    systolic_seq_ctrl #(.N(2), .IDX_W(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .pe_clr(pe_clr2), .pe_hold(pe_hold2), .a_idx(a_idx2), .a_vld(a_vld2),
        .b_idx(b_idx2), .b_vld(b_vld2), .c_rd_vld(c_rd_vld2), .c_rd_row(c_rd_row2)
    );

    typedef struct {
        bit          start;
        logic [30:0] exp;
    } vec_t;

    vec_t v4[1:18];
    vec_t v2[1:10];

    int ncmp = 0;
    int nfail = 0;

    logic [30:0] obs4, obs2;
    assign obs4 = {busy, done, pe_clr, pe_hold, c_rd_vld, c_rd_row,
                   a_vld, b_vld, a_idx, b_idx};
    assign obs2 = {busy2, done2, pe_clr2, pe_hold2, c_rd_vld2, 1'b0, c_rd_row2,
                   2'b0, a_vld2, 2'b0, b_vld2, 6'b0, a_idx2, 6'b0, b_idx2};

    // Behavioural 4x4 output-stationary array fed through the DUT indices.
    int A[4][4], B[4][4], expc[4][4];
    int acc[4][4], ar[4][4], br[4][4], nar[4][4], nbr[4][4];
    int ain, bin;

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
            end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0)
                    ain = (a_vld[i] && !pe_hold) ? A[i][a_idx[i*2 +: 2]] : 0;
                else
                    ain = ar[i][j-1];
                if (i == 0)
                    bin = (b_vld[j] && !pe_hold) ? B[b_idx[j*2 +: 2]][j] : 0;
                else
                    bin = br[i-1][j];
                if (pe_clr) acc[i][j] = 0;
                else        acc[i][j] = acc[i][j] + ain * bin;
                nar[i][j] = ain;
                nbr[i][j] = bin;
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ar[i][j] = nar[i][j];
                br[i][j] = nbr[i][j];
            end
    end

    function automatic logic [30:0] mk(bit bz, bit dn, bit cl, bit hd, bit rv,
                                       logic [1:0] row, logic [3:0] vld,
                                       logic [7:0] idx);
        return {bz, dn, cl, hd, rv, row, vld, vld, idx, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [30:0] got, logic [30:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checki(string name, int got, int exp);
        ncmp++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic run_table4(string name);
        for (int k = 1; k <= 18; k++) begin
            start = v4[k].start;
            tick();
            check(name, obs4, v4[k].exp);
            if (k >= 13 && k <= 16)
                for (int j = 0; j < 4; j++)
                    checki({name, "_c"}, acc[k-13][j], expc[k-13][j]);
        end
        start = 1'b0;
    endtask

    initial begin
        // N=4 single run, start sampled at the first edge; index = cycle.
        v4[1]  = '{1'b1, mk(1,0,1,0,0,2'd0,4'h0,8'h00)};
        v4[2]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h1,8'h00)};
        v4[3]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h3,8'h01)};
        v4[4]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h7,8'h06)};
        v4[5]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'hF,8'h1B)};
        v4[6]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'hE,8'h6C)};
        v4[7]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'hC,8'hB0)};
        v4[8]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h8,8'hC0)};
        v4[9]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h0,8'h00)};
        v4[10] = '{1'b0, mk(1,0,0,0,0,2'd0,4'h0,8'h00)};
        v4[11] = '{1'b0, mk(1,0,0,0,0,2'd0,4'h0,8'h00)};
        v4[12] = '{1'b0, mk(1,0,0,1,0,2'd0,4'h0,8'h00)};
        v4[13] = '{1'b0, mk(1,0,0,1,1,2'd0,4'h0,8'h00)};
        v4[14] = '{1'b0, mk(1,0,0,1,1,2'd1,4'h0,8'h00)};
        v4[15] = '{1'b0, mk(1,0,0,1,1,2'd2,4'h0,8'h00)};
        v4[16] = '{1'b0, mk(1,0,0,1,1,2'd3,4'h0,8'h00)};
        v4[17] = '{1'b0, mk(0,1,0,0,0,2'd0,4'h0,8'h00)};
        v4[18] = '{1'b0, mk(0,0,0,0,0,2'd0,4'h0,8'h00)};
        // N=2 run in the same packed layout (lanes zero-extended).
        v2[1]  = '{1'b1, mk(1,0,1,0,0,2'd0,4'h0,8'h00)};
        v2[2]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h1,8'h00)};
        v2[3]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h3,8'h01)};
        v2[4]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h2,8'h02)};
        v2[5]  = '{1'b0, mk(1,0,0,0,0,2'd0,4'h0,8'h00)};
        v2[6]  = '{1'b0, mk(1,0,0,1,0,2'd0,4'h0,8'h00)};
        v2[7]  = '{1'b0, mk(1,0,0,1,1,2'd0,4'h0,8'h00)};
        v2[8]  = '{1'b0, mk(1,0,0,1,1,2'd1,4'h0,8'h00)};
        v2[9]  = '{1'b0, mk(0,1,0,0,0,2'd0,4'h0,8'h00)};
        v2[10] = '{1'b0, mk(0,0,0,0,0,2'd0,4'h0,8'h00)};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle4", obs4, 31'd0);
            check("idle2", obs2, 31'd0);
        end

        // A = identity, B = 1..16: C rows equal B rows.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = 4*i + j + 1;
                expc[i][j] = 4*i + j + 1;
            end
        run_table4("run_ident");

        // A = all 2, B = all 3: every C = 4*2*3.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j] = 2; B[i][j] = 3; expc[i][j] = 24;
            end
        run_table4("run_const");

        // Abort mid-FEED: rst during cycle 7, cycle 8 idle, no done.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_c8", obs4, 31'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("abort_idle", obs4, 31'd0);
        end
        run_table4("run_after_abort");

        // start held high: DONE re-enters CLEAR, done every 17 cycles.
        start = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            tick();
            check("b2b_done", {30'd0, done}, {30'd0, (k % 17) == 0});
            check("b2b_busy", {30'd0, busy}, {30'd0, (k % 17) != 0});
            if ((k % 17) == 1)
                check("b2b_clr", {30'd0, pe_clr}, 31'd1);
        end
        start = 1'b0;
        tick();
        check("b2b_idle", obs4, 31'd0);

        // N=2 instance.
        for (int k = 1; k <= 10; k++) begin
            start2 = v2[k].start;
            tick();
            check("run_n2", obs2, v2[k].exp);
        end
        start2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
